// File: rtl/z_seq_pkg.sv
// Shared definitions for the serial add/subtract sequencer: state encoding,
// default sizing and the index-width helper.
package z_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } seq_state_e;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefSlice = 4;

    // Ceiling log2 with a floor of 1 so a one-slice build still has an index bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/z_slice_adder.sv
// Combinational SLICE-bit ripple adder built from generate/propagate cells.
// Also reports the carry into the slice MSB for signed-overflow detection.
module z_slice_adder #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [SLICE:0] c;

    // Ripple the carry through per-bit gen/prop cells.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(SLICE); i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
        end
        cout  = c[SLICE];
        c_msb = c[SLICE-1];
    end

endmodule

// File: rtl/z_serial_add_seq.sv
// Multi-cycle add/subtract sequencer: one SLICE-bit slice per clock, LSB first,
// with a registered carry between slices and valid/ready on both sides.
// Optional macro Z_SEQ_ABORT_EN adds an abort input that cancels RUN/DONE.
module z_serial_add_seq
    import z_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned SLICE = DefSlice
) (
    input  logic             clk,
    input  logic             rst,
`ifdef Z_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IW     = clog2_min1(NSLICE);
    localparam logic [IW-1:0] LastIdx = IW'(NSLICE - 1);

    seq_state_e state_q, state_d;

    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q, overflow_q, out_valid_q;

    logic             accept, last_slice, abort_hit;
    logic [SLICE-1:0] sl_a, sl_b, sl_s;
    logic             sl_cout, sl_cmsb;

`ifdef Z_SEQ_ABORT_EN
    assign abort_hit = abort & (state_q != StIdle);
`else
    assign abort_hit = 1'b0;
`endif

    assign sl_a = op_a_q[idx_q*SLICE +: SLICE];
    assign sl_b = op_b_q[idx_q*SLICE +: SLICE];

    z_slice_adder #(
        .SLICE(SLICE)
    ) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .s    (sl_s),
        .cout (sl_cout),
        .c_msb(sl_cmsb)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and in_ready.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        accept     = 1'b0;
        last_slice = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                last_slice = (idx_q == LastIdx);
                if (last_slice) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Abort outranks every other transition outside IDLE.
        if (abort_hit) begin
            state_d    = StIdle;
            last_slice = 1'b0;
        end
    end

    // Operand, carry, index and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            carry_q     <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (abort_hit) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + ~borrow.
            op_a_q  <= a;
            op_b_q  <= sub ? ~b : b;
            carry_q <= sub ? ~c_in : c_in;
            idx_q   <= '0;
        end else if (state_q == StRun) begin
            sum_q[idx_q*SLICE +: SLICE] <= sl_s;
            carry_q <= sl_cout;
            if (last_slice) begin
                c_out_q     <= sl_cout;
                overflow_q  <= sl_cmsb ^ sl_cout;
                out_valid_q <= 1'b1;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end else if (state_q == StDone && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign overflow  = overflow_q;

endmodule
